// File: rtl/lisnoc_pkg.sv
// Shared LISNoC definitions: flit type codes, default flit layout, header field helpers.
package lisnoc_pkg;

    localparam int unsigned FLIT_TYPE_WIDTH = 2;
    localparam int unsigned FLIT_DATA_WIDTH = 32;

    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_HEADER  = 2'b01;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_LAST    = 2'b10;
    localparam logic [FLIT_TYPE_WIDTH-1:0] FLIT_SINGLE  = 2'b11;

    typedef struct packed {
        logic [FLIT_TYPE_WIDTH-1:0] ftype;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } pkt_state_e;

    // Header field extraction for the default 32-bit layout (dest 5b at top, prio [3:0], src [20:16]).
    function automatic logic [4:0] hdr_dest(input logic [FLIT_DATA_WIDTH-1:0] data);
        return data[FLIT_DATA_WIDTH-1 -: 5];
    endfunction

    function automatic logic [3:0] hdr_prio(input logic [FLIT_DATA_WIDTH-1:0] data);
        return data[3:0];
    endfunction

    function automatic logic [4:0] hdr_src(input logic [FLIT_DATA_WIDTH-1:0] data);
        return data[20:16];
    endfunction

    function automatic bit ranges_overlap(input int unsigned a_lo, input int unsigned a_width,
                                          input int unsigned b_lo, input int unsigned b_width);
        return (a_lo < b_lo + b_width) && (b_lo < a_lo + a_width);
    endfunction

endpackage

// File: rtl/lisnoc_na_packetizer_if.sv
// Command, payload and per-VC flit handshake bundle of the NA packetizer.
interface lisnoc_na_packetizer_if #(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned vchannels       = 2,
    parameter int unsigned ph_dest_width   = 5,
    parameter int unsigned ph_prio_width   = 4,
    parameter int unsigned len_width       = 8
);
    localparam int unsigned flit_width = flit_data_width + flit_type_width;
    localparam int unsigned vc_width   = (vchannels > 1) ? $clog2(vchannels) : 1;

    logic                       cmd_valid_i;
    logic                       cmd_ready_o;
    logic [ph_dest_width-1:0]   cmd_dest_i;
    logic [ph_prio_width-1:0]   cmd_prio_i;
    logic [vc_width-1:0]        cmd_vc_i;
    logic [len_width-1:0]       cmd_len_i;
    logic [flit_data_width-1:0] data_i;
    logic                       data_valid_i;
    logic                       data_ready_o;
    logic [flit_width-1:0]      out_flit_o;
    logic [vchannels-1:0]       out_valid_o;
    logic [vchannels-1:0]       out_ready_i;
    logic                       err_o;

    modport slave (
        input  cmd_valid_i, cmd_dest_i, cmd_prio_i, cmd_vc_i, cmd_len_i,
        input  data_i, data_valid_i, out_ready_i,
        output cmd_ready_o, data_ready_o, out_flit_o, out_valid_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_dest_i, cmd_prio_i, cmd_vc_i, cmd_len_i,
        output data_i, data_valid_i, out_ready_i,
        input  cmd_ready_o, data_ready_o, out_flit_o, out_valid_o, err_o
    );

endinterface

// File: rtl/lisnoc_na_outreg.sv
// One-entry output flit slot; valid is held as a one-hot VC mask so drain needs no decode.
module lisnoc_na_outreg #(
    parameter int unsigned flit_width = 34,
    parameter int unsigned vchannels  = 2,
    parameter int unsigned vc_width   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [flit_width-1:0] flit_i,
    input  logic [vc_width-1:0]   vc_i,
    input  logic [vchannels-1:0]  ready_i,
    output logic [flit_width-1:0] flit_o,
    output logic [vchannels-1:0]  valid_o,
    output logic                  slot_free_c_o
);
    logic [flit_width-1:0] flit_q, flit_d;
    logic [vchannels-1:0]  valid_q, valid_d;
    logic                  drain_c;

    // Only ready on the occupied VC can drain the slot.
    assign drain_c       = |(valid_q & ready_i);
    assign slot_free_c_o = ~(|valid_q) | drain_c;

    always_comb begin
        flit_d  = flit_q;
        valid_d = valid_q;
        if (load_i) begin
            flit_d  = flit_i;
            valid_d = vchannels'(1) << vc_i;
        end else if (drain_c) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_q  <= '0;
            valid_q <= '0;
        end else begin
            flit_q  <= flit_d;
            valid_q <= valid_d;
        end
    end

    assign flit_o  = flit_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/lisnoc_na_packetizer.sv
// NA transmit stage: turns a message command plus payload stream into a header/payload/last
// flit sequence on one virtual channel of the router local port.
module lisnoc_na_packetizer
    import lisnoc_pkg::*;
#(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned vchannels       = 2,
    parameter int unsigned ph_dest_width   = 5,
    parameter int unsigned ph_prio_width   = 4,
    parameter int unsigned ph_prio_offset  = 0,
    parameter int unsigned ph_src_offset   = 16,
    parameter int unsigned src_id          = 0,
    parameter int unsigned len_width       = 8
) (
    input  logic clk,
    input  logic rst,
    lisnoc_na_packetizer_if.slave bus
);
    localparam int unsigned flit_width = flit_data_width + flit_type_width;
    localparam int unsigned vc_width   = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam int unsigned dest_lo    = flit_data_width - ph_dest_width;

    if (ranges_overlap(dest_lo, ph_dest_width, ph_prio_offset, ph_prio_width) ||
        ranges_overlap(dest_lo, ph_dest_width, ph_src_offset, ph_dest_width) ||
        ranges_overlap(ph_prio_offset, ph_prio_width, ph_src_offset, ph_dest_width)) begin : g_hdr_overlap
        $error("lisnoc_na_packetizer: header fields overlap");
    end

    pkt_state_e                 state_q, state_d;
    logic [vc_width-1:0]        vc_q, vc_d;
    logic [len_width-1:0]       rem_q, rem_d;
    logic                       err_q, err_d;
    logic                       slot_free_c, load_c, vc_illegal_c;
    logic                       cmd_ready_c, data_ready_c;
    logic [vc_width-1:0]        cmd_vc_c, ld_vc_c;
    logic [flit_type_width-1:0] ld_type_c;
    logic [flit_data_width-1:0] ld_data_c, header_c;

    // VC codes beyond vchannels exist only when vchannels is not a power of two.
    if ((1 << vc_width) > vchannels) begin : g_vc_chk
        assign vc_illegal_c = (bus.cmd_vc_i >= vc_width'(vchannels));
    end else begin : g_vc_pow2
        assign vc_illegal_c = 1'b0;
    end
    assign cmd_vc_c = vc_illegal_c ? '0 : bus.cmd_vc_i;

    always_comb begin
        header_c = '0;
        header_c[flit_data_width-1 -: ph_dest_width] = bus.cmd_dest_i;
        header_c[ph_prio_offset +: ph_prio_width]    = bus.cmd_prio_i;
        header_c[ph_src_offset +: ph_dest_width]     = ph_dest_width'(src_id);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vc_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.cmd_valid_i && slot_free_c && (bus.cmd_len_i != '0)) state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (bus.data_valid_i && slot_free_c && (rem_q == len_width'(1))) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshakes, slot load and datapath register updates.
    always_comb begin
        cmd_ready_c  = 1'b0;
        data_ready_c = 1'b0;
        load_c       = 1'b0;
        ld_type_c    = flit_type_width'(FLIT_PAYLOAD);
        ld_data_c    = bus.data_i;
        ld_vc_c      = vc_q;
        vc_d         = vc_q;
        rem_d        = rem_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_c = slot_free_c;
                if (bus.cmd_valid_i && slot_free_c) begin
                    load_c    = 1'b1;
                    ld_type_c = (bus.cmd_len_i == '0) ? flit_type_width'(FLIT_SINGLE)
                                                      : flit_type_width'(FLIT_HEADER);
                    ld_data_c = header_c;
                    ld_vc_c   = cmd_vc_c;
                    vc_d      = cmd_vc_c;
                    rem_d     = bus.cmd_len_i;
                    err_d     = err_q | vc_illegal_c;
                end
            end
            ST_PAYLOAD: begin
                data_ready_c = slot_free_c;
                if (bus.data_valid_i && slot_free_c) begin
                    load_c    = 1'b1;
                    ld_type_c = (rem_q == len_width'(1)) ? flit_type_width'(FLIT_LAST)
                                                         : flit_type_width'(FLIT_PAYLOAD);
                    rem_d     = rem_q - len_width'(1);
                end
            end
            default: ;
        endcase
    end

    lisnoc_na_outreg #(
        .flit_width (flit_width),
        .vchannels  (vchannels),
        .vc_width   (vc_width)
    ) u_outreg (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_c),
        .flit_i        ({ld_type_c, ld_data_c}),
        .vc_i          (ld_vc_c),
        .ready_i       (bus.out_ready_i),
        .flit_o        (bus.out_flit_o),
        .valid_o       (bus.out_valid_o),
        .slot_free_c_o (slot_free_c)
    );

    assign bus.cmd_ready_o  = cmd_ready_c;
    assign bus.data_ready_o = data_ready_c;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_lisnoc_na_packetizer.sv
// Directed bench: per-cycle vector table on a 2-VC instance, hand sequences for illegal VC and reset.
module tb_lisnoc_na_packetizer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lisnoc_na_packetizer_if #(.vchannels(2)) bus2 ();
    lisnoc_na_packetizer_if #(.vchannels(3)) bus3 ();

    lisnoc_na_packetizer #(.vchannels(2), .src_id(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    lisnoc_na_packetizer #(.vchannels(3), .src_id(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        logic        cv;
        logic [4:0]  dest;
        logic [3:0]  prio;
        logic        vc;
        logic [7:0]  len;
        logic        dv;
        logic [31:0] data;
        logic [1:0]  ordy;
        logic [1:0]  ev;
        logic [33:0] ef;
        logic        ecr;
        logic        edr;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic cv, input logic [4:0] dest, input logic [3:0] prio,
                                input logic vc, input logic [7:0] len, input logic dv,
                                input logic [31:0] data, input logic [1:0] ordy, input logic [1:0] ev,
                                input logic [33:0] ef, input logic ecr, input logic edr);
        vec_t v;
        v.cv = cv; v.dest = dest; v.prio = prio; v.vc = vc; v.len = len; v.dv = dv;
        v.data = data; v.ordy = ordy; v.ev = ev; v.ef = ef; v.ecr = ecr; v.edr = edr;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        bus2.cmd_valid_i = 0; bus2.cmd_dest_i = 0; bus2.cmd_prio_i = 0; bus2.cmd_vc_i = 0;
        bus2.cmd_len_i = 0; bus2.data_i = 0; bus2.data_valid_i = 0; bus2.out_ready_i = 2'b11;
        bus3.cmd_valid_i = 0; bus3.cmd_dest_i = 0; bus3.cmd_prio_i = 0; bus3.cmd_vc_i = 0;
        bus3.cmd_len_i = 0; bus3.data_i = 0; bus3.data_valid_i = 0; bus3.out_ready_i = 3'b111;

        // cv dest prio vc len dv data ordy | ev flit cmd_ready data_ready
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     2'b11, 2'b00, 34'h0, 1, 0));
        vecs.push_back(mk(1, 5, 3, 1, 0, 0, 32'h0,     2'b11, 2'b00, 34'h0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     2'b11, 2'b10, {2'b11, 32'h2801_0003}, 1, 0));
        vecs.push_back(mk(1, 2, 1, 0, 3, 0, 32'h0,     2'b11, 2'b00, 34'h0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA,     2'b11, 2'b01, {2'b01, 32'h1001_0001}, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB,     2'b11, 2'b01, {2'b00, 32'hA}, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC,     2'b11, 2'b01, {2'b00, 32'hB}, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     2'b11, 2'b01, {2'b10, 32'hC}, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hDEAD,  2'b11, 2'b00, 34'h0, 1, 0));
        vecs.push_back(mk(1, 7, 2, 0, 2, 0, 32'h0,     2'b11, 2'b00, 34'h0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h11,    2'b11, 2'b01, {2'b01, 32'h3801_0002}, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,    2'b10, 2'b01, {2'b00, 32'h11}, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,    2'b00, 2'b01, {2'b00, 32'h11}, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,    2'b10, 2'b01, {2'b00, 32'h11}, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,    2'b00, 2'b01, {2'b00, 32'h11}, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,    2'b11, 2'b01, {2'b00, 32'h11}, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0,     2'b11, 2'b01, {2'b10, 32'h22}, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h55,    2'b11, 2'b01, {2'b01, 32'h0801_0000}, 0, 1));
        vecs.push_back(mk(1, 3, 15, 1, 1, 0, 32'h0,    2'b11, 2'b01, {2'b10, 32'h55}, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h66,    2'b11, 2'b10, {2'b01, 32'h1801_000F}, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     2'b11, 2'b10, {2'b10, 32'h66}, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,     2'b11, 2'b00, 34'h0, 1, 0));

        #12;
        chk("rst.valid",  64'(bus2.out_valid_o), 64'h0);
        chk("rst.flit",   64'(bus2.out_flit_o), 64'h0);
        chk("rst.err",    64'(bus2.err_o), 64'h0);
        chk("rst.cready", 64'(bus2.cmd_ready_o), 64'h1);
        chk("rst.dready", 64'(bus2.data_ready_o), 64'h0);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            bus2.cmd_valid_i  = vecs[i].cv;
            bus2.cmd_dest_i   = vecs[i].dest;
            bus2.cmd_prio_i   = vecs[i].prio;
            bus2.cmd_vc_i     = vecs[i].vc;
            bus2.cmd_len_i    = vecs[i].len;
            bus2.data_valid_i = vecs[i].dv;
            bus2.data_i       = vecs[i].data;
            bus2.out_ready_i  = vecs[i].ordy;
            #1;
            chk($sformatf("row%0d.valid", i), 64'(bus2.out_valid_o), 64'(vecs[i].ev));
            if (vecs[i].ev != 2'b00)
                chk($sformatf("row%0d.flit", i), 64'(bus2.out_flit_o), 64'(vecs[i].ef));
            chk($sformatf("row%0d.cready", i), 64'(bus2.cmd_ready_o), 64'(vecs[i].ecr));
            chk($sformatf("row%0d.dready", i), 64'(bus2.data_ready_o), 64'(vecs[i].edr));
        end
        chk("table.err", 64'(bus2.err_o), 64'h0);

        // Illegal VC on the 3-VC instance maps to VC 0 and latches err_o.
        @(posedge clk); #1;
        bus3.cmd_valid_i = 1; bus3.cmd_dest_i = 4; bus3.cmd_prio_i = 1; bus3.cmd_vc_i = 2'd3; bus3.cmd_len_i = 0;
        #1;
        chk("ivc.err_before", 64'(bus3.err_o), 64'h0);
        chk("ivc.cready", 64'(bus3.cmd_ready_o), 64'h1);
        @(posedge clk); #1;
        bus3.cmd_valid_i = 0;
        #1;
        chk("ivc.valid", 64'(bus3.out_valid_o), 64'b001);
        chk("ivc.flit",  64'(bus3.out_flit_o), 64'({2'b11, 32'h2001_0001}));
        chk("ivc.err",   64'(bus3.err_o), 64'h1);
        @(posedge clk); #1;
        bus3.cmd_valid_i = 1; bus3.cmd_vc_i = 2'd2;
        #1;
        chk("ivc2.valid_drained", 64'(bus3.out_valid_o), 64'b000);
        @(posedge clk); #1;
        bus3.cmd_valid_i = 0;
        #1;
        chk("ivc2.valid", 64'(bus3.out_valid_o), 64'b100);
        chk("ivc2.err",   64'(bus3.err_o), 64'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("ivc.err_sticky", 64'(bus3.err_o), 64'h1);

        // Asynchronous reset in the middle of a packet, then a clean single-flit packet.
        @(posedge clk); #1;
        bus2.cmd_valid_i = 1; bus2.cmd_dest_i = 2; bus2.cmd_prio_i = 1; bus2.cmd_vc_i = 1; bus2.cmd_len_i = 2;
        bus2.data_valid_i = 0; bus2.out_ready_i = 2'b11;
        @(posedge clk); #1;
        bus2.cmd_valid_i = 0;
        #1;
        chk("mrst.hdr_valid", 64'(bus2.out_valid_o), 64'b10);
        chk("mrst.dready",    64'(bus2.data_ready_o), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("mrst.valid",  64'(bus2.out_valid_o), 64'h0);
        chk("mrst.flit",   64'(bus2.out_flit_o), 64'h0);
        chk("mrst.cready", 64'(bus2.cmd_ready_o), 64'h1);
        chk("mrst.dready0", 64'(bus2.data_ready_o), 64'h0);
        chk("mrst.err3",   64'(bus3.err_o), 64'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        bus2.cmd_valid_i = 1; bus2.cmd_dest_i = 6; bus2.cmd_prio_i = 0; bus2.cmd_vc_i = 0; bus2.cmd_len_i = 0;
        #1;
        chk("post.cready", 64'(bus2.cmd_ready_o), 64'h1);
        @(posedge clk); #1;
        bus2.cmd_valid_i = 0;
        #1;
        chk("post.valid",  64'(bus2.out_valid_o), 64'b01);
        chk("post.flit",   64'(bus2.out_flit_o), 64'({2'b11, 32'h3001_0000}));
        chk("post.dready", 64'(bus2.data_ready_o), 64'h0);
        @(posedge clk); #2;
        chk("post.drained", 64'(bus2.out_valid_o), 64'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
